// File: rtl/lighthouse_pkg.sv
// lighthouse_pkg: shared thresholds, event-word layout, pulse classes and
// small saturating helpers for the multi-channel lighthouse decoder.
package lighthouse_pkg;

   // Event word layout: [31:13] sweep, [12] valid, [11] data, [10] rotor,
   // [9] lighthouse, [8:0] channel.
   localparam int EV_SWEEP_W   = 19;
   localparam int EV_CHAN_W    = 9;
   localparam int EV_SWEEP_LSB = 13;
   localparam int EV_VALID_BIT = 12;
   localparam int EV_DATA_BIT  = 11;
   localparam int EV_ROTOR_BIT = 10;
   localparam int EV_LH_BIT    = 9;
   localparam int EV_CHAN_LSB  = 0;

   localparam int unsigned DEF_SWEEP_MAX      = 55;
   localparam int unsigned DEF_SYNC_MIN       = 58;
   localparam int unsigned DEF_SKIP_MIN       = 100;
   localparam int unsigned DEF_SKIP_MAX       = 140;
   localparam int unsigned DEF_SWEEP_VALID_LO = 300;
   localparam int unsigned DEF_SWEEP_VALID_HI = 8000;
   localparam int unsigned DEF_SYNC_GAP_NOM   = 8333;
   localparam int unsigned DEF_SYNC_GAP_TOL   = 300;

   typedef enum logic [1:0] {
      PC_SWEEP,
      PC_SYNC,
      PC_SKIP,
      PC_GLITCH
   } pulse_class_e;

   typedef struct packed {
      logic [EV_SWEEP_W-1:0] sweep;
      logic                  valid;
      logic                  data;
      logic                  rotor;
      logic                  lighthouse;
      logic [EV_CHAN_W-1:0]  chan;
   } event_t;

   function automatic logic [EV_SWEEP_W-1:0] sat_sweep(input logic [31:0] value);
      if (|value[31:EV_SWEEP_W]) return '1;
      return value[EV_SWEEP_W-1:0];
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] count, input logic [5:0] inc);
      logic [16:0] sum;
      sum = {1'b0, count} + {11'b0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/lighthouse_channel.sv
// lighthouse_channel: one photodiode line -- synchroniser, pulse timing,
// sync/sweep classification, lighthouse ID and a one-entry event buffer.
module lighthouse_channel
   import lighthouse_pkg::*;
#(
   parameter int          CHAN_IDX       = 0,
   parameter int unsigned SWEEP_MAX      = DEF_SWEEP_MAX,
   parameter int unsigned SYNC_MIN       = DEF_SYNC_MIN,
   parameter int unsigned SKIP_MIN       = DEF_SKIP_MIN,
   parameter int unsigned SKIP_MAX       = DEF_SKIP_MAX,
   parameter int unsigned SWEEP_VALID_LO = DEF_SWEEP_VALID_LO,
   parameter int unsigned SWEEP_VALID_HI = DEF_SWEEP_VALID_HI,
   parameter int unsigned SYNC_GAP_NOM   = DEF_SYNC_GAP_NOM,
   parameter int unsigned SYNC_GAP_TOL   = DEF_SYNC_GAP_TOL
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_sensor,
   input  logic [31:0] i_timer,
   input  logic        i_grant,
   output logic        o_pending,
   output event_t      o_event,
   output logic        o_glitch,
   output logic        o_overflow
);

   localparam logic [31:0] L_SWEEP_MAX = 32'(SWEEP_MAX);
   localparam logic [31:0] L_SYNC_MIN  = 32'(SYNC_MIN);
   localparam logic [31:0] L_SKIP_MIN  = 32'(SKIP_MIN);
   localparam logic [31:0] L_SKIP_MAX  = 32'(SKIP_MAX);
   localparam logic [31:0] L_VALID_LO  = 32'(SWEEP_VALID_LO);
   localparam logic [31:0] L_VALID_HI  = 32'(SWEEP_VALID_HI);
   localparam logic [31:0] L_GAP_HI    = 32'(SYNC_GAP_NOM + SYNC_GAP_TOL);
   localparam logic [31:0] L_GAP_LO    = 32'(SYNC_GAP_NOM - SYNC_GAP_TOL);

   // Width buckets: the two lower buckets take the floor quarter-span, the two
   // upper ones the ceiling quarter-span (58/68/78/89/100 for the defaults).
   localparam int unsigned STEP_LO = (SKIP_MIN - SYNC_MIN) / 4;
   localparam int unsigned STEP_HI = (SKIP_MIN - SYNC_MIN + 3) / 4;
   localparam logic [31:0] BKT_1   = 32'(SYNC_MIN + STEP_LO);
   localparam logic [31:0] BKT_2   = 32'(SKIP_MIN - 2 * STEP_HI);
   localparam logic [31:0] BKT_3   = 32'(SKIP_MIN - STEP_HI);

   logic         r_sync1, r_sync2, r_sync3;
   logic         w_rise, w_fall;
   logic [31:0]  r_t_rise, r_t_sync, r_t_prev_sync;
   logic         r_have_sync, r_have_prev;
   logic         r_lighthouse, r_rotor, r_data;
   logic         r_pending;
   event_t       r_event;
   logic [31:0]  w_dur, w_sweep, w_gap;
   pulse_class_e w_class;
   logic [1:0]   w_bucket;
   logic         w_is_sync, w_new_event;
   event_t       w_event;

   // NOTE: non-blocking assignments make the three flops a true shift chain;
   // blocking ones would collapse it into a single stage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= i_sensor;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_rise  = r_sync2 & ~r_sync3;
   assign w_fall  = ~r_sync2 & r_sync3;
   assign w_dur   = i_timer - r_t_rise;
   assign w_sweep = r_t_rise - r_t_sync;
   assign w_gap   = r_t_rise - r_t_prev_sync;

   // NOTE: every output of this block gets a default first, so no path
   // through the if-chain can infer a latch.
   always_comb begin
      w_class  = PC_GLITCH;
      w_bucket = 2'b11;
      if (w_dur < L_SWEEP_MAX)                           w_class = PC_SWEEP;
      else if (w_dur >= L_SYNC_MIN && w_dur < L_SKIP_MIN) w_class = PC_SYNC;
      else if (w_dur >= L_SKIP_MIN && w_dur < L_SKIP_MAX) w_class = PC_SKIP;
      if (w_dur < BKT_1)      w_bucket = 2'b00;
      else if (w_dur < BKT_2) w_bucket = 2'b01;
      else if (w_dur < BKT_3) w_bucket = 2'b10;
   end

   assign w_is_sync   = w_fall && (w_class == PC_SYNC || w_class == PC_SKIP);
   assign w_new_event = w_fall && (w_class == PC_SWEEP) && r_have_sync;
   assign o_glitch    = w_fall && (w_class == PC_GLITCH);
   assign o_overflow  = w_new_event && r_pending && !i_grant;

   always_comb begin
      w_event            = '0;
      w_event.sweep      = sat_sweep(w_sweep);
      w_event.valid      = (w_sweep >= L_VALID_LO) && (w_sweep <= L_VALID_HI);
      w_event.data       = r_data;
      w_event.rotor      = r_rotor;
      w_event.lighthouse = r_lighthouse;
      w_event.chan       = EV_CHAN_W'(CHAN_IDX);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_t_rise      <= '0;
         r_t_sync      <= '0;
         r_t_prev_sync <= '0;
         r_have_sync   <= 1'b0;
         r_have_prev   <= 1'b0;
         r_lighthouse  <= 1'b0;
         r_rotor       <= 1'b0;
         r_data        <= 1'b0;
      end else begin
         if (w_rise) r_t_rise <= i_timer;
         // Skip syncs feed only the gap tracker; the sweep reference stays put.
         if (w_is_sync) begin
            r_t_prev_sync <= r_t_rise;
            r_have_prev   <= 1'b1;
            if (r_have_prev) begin
               if (w_gap > L_GAP_HI)      r_lighthouse <= 1'b1;
               else if (w_gap < L_GAP_LO) r_lighthouse <= 1'b0;
            end
         end
         if (w_fall && w_class == PC_SYNC) begin
            r_t_sync    <= r_t_rise;
            r_have_sync <= 1'b1;
            r_data      <= w_bucket[1];
            r_rotor     <= w_bucket[0];
         end
      end
   end

   // A new event always wins the buffer; a same-cycle grant has already
   // taken the old word, so only an ungranted overwrite counts as overflow.
   // NOTE: the buffer word is reset along with its flag so a reset mid-flight
   // can never surface a stale event.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pending <= 1'b0;
         r_event   <= '0;
      end else if (w_new_event) begin
         r_pending <= 1'b1;
         r_event   <= w_event;
      end else if (i_grant) begin
         r_pending <= 1'b0;
      end
   end

   assign o_pending = r_pending;
   assign o_event   = r_event;

endmodule

// File: rtl/lighthouse_multi_decoder.sv
// lighthouse_multi_decoder: NUM_SENSORS pulse-decoding channels merged onto one
// valid/ready event stream by a round-robin arbiter, with shared counters.
module lighthouse_multi_decoder
   import lighthouse_pkg::*;
#(
   parameter int          NUM_SENSORS    = 4,
   parameter int unsigned SWEEP_MAX      = DEF_SWEEP_MAX,
   parameter int unsigned SYNC_MIN       = DEF_SYNC_MIN,
   parameter int unsigned SKIP_MIN       = DEF_SKIP_MIN,
   parameter int unsigned SKIP_MAX       = DEF_SKIP_MAX,
   parameter int unsigned SWEEP_VALID_LO = DEF_SWEEP_VALID_LO,
   parameter int unsigned SWEEP_VALID_HI = DEF_SWEEP_VALID_HI,
   parameter int unsigned SYNC_GAP_NOM   = DEF_SYNC_GAP_NOM,
   parameter int unsigned SYNC_GAP_TOL   = DEF_SYNC_GAP_TOL
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_SENSORS-1:0] sensor_signal,
   input  logic [31:0]            timer,
   output logic [31:0]            sensor_data,
   output logic                   data_valid,
   input  logic                   data_ready,
   output logic [15:0]            overflow_count,
   output logic [15:0]            glitch_count
);

   localparam int PTR_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

   logic [NUM_SENSORS-1:0] w_pending, w_glitch, w_overflow, w_grant;
   event_t                 w_event [NUM_SENSORS];
   logic [PTR_W-1:0]       r_rr_ptr, w_sel, w_idx;
   logic                   w_found, w_can_load;
   logic                   r_data_valid;
   logic [31:0]            r_sensor_data;
   logic [15:0]            r_overflow_count, r_glitch_count;
   logic [5:0]             w_glitch_n, w_overflow_n;

   for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_chan
      lighthouse_channel #(
         .CHAN_IDX       (g),
         .SWEEP_MAX      (SWEEP_MAX),
         .SYNC_MIN       (SYNC_MIN),
         .SKIP_MIN       (SKIP_MIN),
         .SKIP_MAX       (SKIP_MAX),
         .SWEEP_VALID_LO (SWEEP_VALID_LO),
         .SWEEP_VALID_HI (SWEEP_VALID_HI),
         .SYNC_GAP_NOM   (SYNC_GAP_NOM),
         .SYNC_GAP_TOL   (SYNC_GAP_TOL)
      ) u_chan (
         .clk        (clk),
         .reset_n    (reset_n),
         .i_sensor   (sensor_signal[g]),
         .i_timer    (timer),
         .i_grant    (w_grant[g]),
         .o_pending  (w_pending[g]),
         .o_event    (w_event[g]),
         .o_glitch   (w_glitch[g]),
         .o_overflow (w_overflow[g])
      );
   end

   assign w_can_load = !r_data_valid || data_ready;

   // r_rr_ptr holds last_grant+1: the search starts there and wraps.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_SENSORS; k++) begin
         w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_SENSORS);
         if (!w_found && w_pending[w_idx]) begin
            w_found = 1'b1;
            w_sel   = w_idx;
         end
      end
   end

   always_comb begin
      w_grant = '0;
      if (w_can_load && w_found) w_grant[w_sel] = 1'b1;
   end

   always_comb begin
      w_glitch_n   = '0;
      w_overflow_n = '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         w_glitch_n   = w_glitch_n + 6'(w_glitch[i]);
         w_overflow_n = w_overflow_n + 6'(w_overflow[i]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr         <= '0;
         r_data_valid     <= 1'b0;
         r_sensor_data    <= '0;
         r_overflow_count <= '0;
         r_glitch_count   <= '0;
      end else begin
         if (w_can_load) begin
            r_data_valid <= w_found;
            if (w_found) begin
               r_sensor_data <= w_event[w_sel];
               r_rr_ptr      <= (w_sel == PTR_W'(NUM_SENSORS - 1)) ? '0 : w_sel + PTR_W'(1);
            end
         end
         r_glitch_count   <= sat_add16(r_glitch_count, w_glitch_n);
         r_overflow_count <= sat_add16(r_overflow_count, w_overflow_n);
      end
   end

   assign sensor_data    = r_sensor_data;
   assign data_valid     = r_data_valid;
   assign overflow_count = r_overflow_count;
   assign glitch_count   = r_glitch_count;

endmodule

// File: tb/tb_lighthouse_multi_decoder.sv
// Directed bench for lighthouse_multi_decoder: hand-computed event words for
// sync decoding, lighthouse ID, timer wrap, arbitration, overflow and glitches.
module tb_lighthouse_multi_decoder;

   localparam int N = 4;

   logic          clk           = 1'b0;
   logic          reset_n       = 1'b0;
   logic [N-1:0]  sensor_signal = '0;
   logic [31:0]   timer         = '0;
   logic          data_ready    = 1'b1;
   logic [31:0]   sensor_data;
   logic          data_valid;
   logic [15:0]   overflow_count;
   logic [15:0]   glitch_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lighthouse_multi_decoder #(.NUM_SENSORS(N)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sensor_signal  (sensor_signal),
      .timer          (timer),
      .sensor_data    (sensor_data),
      .data_valid     (data_valid),
      .data_ready     (data_ready),
      .overflow_count (overflow_count),
      .glitch_count   (glitch_count)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 ns after the edge; the timer advances one tick per clock.
   task automatic tick();
      @(posedge clk);
      #1;
      timer = timer + 32'd1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   // Pin(s) high for exactly 'width' sampled edges, starting with timer = t0.
   task automatic pulse(input logic [N-1:0] mask, input logic [31:0] t0, input int width);
      timer         = t0;
      sensor_signal = sensor_signal | mask;
      repeat (width) tick();
      sensor_signal = sensor_signal & ~mask;
   endtask

   task automatic wait_event(input string tag, input logic [31:0] exp, output int lat);
      lat = 0;
      while (data_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_valid"}, {31'b0, data_valid}, 32'd1);
      check(tag, sensor_data, exp);
   endtask

   function automatic logic [31:0] word(input logic [18:0] sweep, input logic v, input logic d,
                                        input logic r, input logic lh, input logic [8:0] ch);
      return {sweep, v, d, r, lh, ch};
   endfunction

   initial begin
      int lat;
      logic seen;

      // Reset state
      ticks(3);
      check("rst_data", sensor_data, 32'd0);
      check("rst_valid", {31'b0, data_valid}, 32'd0);
      check("rst_ovf", {16'b0, overflow_count}, 32'd0);
      check("rst_glitch", {16'b0, glitch_count}, 32'd0);
      reset_n = 1'b1;
      tick();

      // Sync w62 then sweep 4000 ticks later: first sync only seeds the gap tracker
      pulse(4'b0001, 32'd1000, 62);
      ticks(4);
      pulse(4'b0001, 32'd5000, 10);
      wait_event("a_sweep", word(19'd4000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0), lat);
      check("a_latency", 32'(lat), 32'd4);
      tick();
      check("a_drop", {31'b0, data_valid}, 32'd0);

      // Width buckets, gaps of 8333 hold lighthouse at 0
      pulse(4'b0001, 32'd9333, 72);
      ticks(4);
      pulse(4'b0001, 32'd10333, 10);
      wait_event("b_w72", word(19'd1000, 1'b1, 1'b0, 1'b1, 1'b0, 9'd0), lat);
      pulse(4'b0001, 32'd17666, 83);
      ticks(4);
      pulse(4'b0001, 32'd18666, 10);
      wait_event("b_w83", word(19'd1000, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0), lat);
      pulse(4'b0001, 32'd25999, 95);
      ticks(4);
      pulse(4'b0001, 32'd26999, 10);
      wait_event("b_w95", word(19'd1000, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0), lat);

      // Gaps 8000 -> 0, 8700 -> 1, 8400 -> hold 1
      pulse(4'b0001, 32'd33999, 62);
      ticks(4);
      pulse(4'b0001, 32'd35999, 10);
      wait_event("c_gap8000", word(19'd2000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0), lat);
      pulse(4'b0001, 32'd42699, 62);
      ticks(4);
      pulse(4'b0001, 32'd44699, 10);
      wait_event("c_gap8700", word(19'd2000, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0), lat);
      pulse(4'b0001, 32'd51099, 62);
      ticks(4);
      pulse(4'b0001, 32'd53099, 10);
      wait_event("c_gap8400", word(19'd2000, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0), lat);

      // Timer wrap (huge gap -> lighthouse 1), then a saturating sweep
      pulse(4'b0001, 32'hFFFF_FFF0, 62);
      ticks(4);
      pulse(4'b0001, 32'h0000_0F00, 10);
      wait_event("d_wrap", word(19'h00F10, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0), lat);
      pulse(4'b0001, 32'h0010_0000, 10);
      wait_event("d_sat", word(19'h7FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0), lat);

      // Skip sync (w120): gap 0x110 -> lighthouse 0, sweep reference unchanged
      pulse(4'b0001, 32'h0000_0100, 120);
      ticks(4);
      pulse(4'b0001, 32'h0000_0200, 10);
      wait_event("s_skip", word(19'h00210, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0), lat);

      // Glitch widths on a synced channel: counted, never an event
      pulse(4'b0001, 32'd70000, 57);
      ticks(4);
      check("g_w57_cnt", {16'b0, glitch_count}, 32'd1);
      check("g_w57_noev", {31'b0, data_valid}, 32'd0);
      pulse(4'b0001, 32'd71000, 150);
      ticks(4);
      check("g_w150_cnt", {16'b0, glitch_count}, 32'd2);
      check("g_w150_noev", {31'b0, data_valid}, 32'd0);
      pulse(4'b0001, 32'd72000, 55);
      ticks(4);
      check("g_w55_cnt", {16'b0, glitch_count}, 32'd3);

      // Held event (sweep 8208 is out of range), then reset mid-pulse
      data_ready = 1'b0;
      pulse(4'b0001, 32'h0000_2000, 10);
      wait_event("h_invalid", word(19'h02010, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0), lat);
      sensor_signal[0] = 1'b1;
      ticks(3);
      check("h_stable", sensor_data, word(19'h02010, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0));
      reset_n = 1'b0;
      tick();
      check("r_data", sensor_data, 32'd0);
      check("r_valid", {31'b0, data_valid}, 32'd0);
      check("r_glitch", {16'b0, glitch_count}, 32'd0);
      check("r_ovf", {16'b0, overflow_count}, 32'd0);
      reset_n    = 1'b1;
      data_ready = 1'b1;
      ticks(3);
      sensor_signal[0] = 1'b0;
      ticks(6);
      pulse(4'b0001, 32'h0000_3000, 10);
      seen = 1'b0;
      repeat (12) begin
         tick();
         if (data_valid === 1'b1) seen = 1'b1;
      end
      check("r_no_sync_drop", {31'b0, seen}, 32'd0);

      // All four channels fall together while the consumer stalls
      pulse(4'b1111, 32'h0001_0000, 62);
      ticks(4);
      data_ready = 1'b0;
      pulse(4'b1111, 32'h0001_0000 + 32'd1000, 10);
      wait_event("e_ch0", word(19'd1000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0), lat);
      ticks(10);
      check("e_ch0_stable", sensor_data, word(19'd1000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0));
      check("e_ch0_held", {31'b0, data_valid}, 32'd1);
      data_ready = 1'b1;
      tick();
      check("e_ch1", sensor_data, word(19'd1000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd1));
      tick();
      check("e_ch2", sensor_data, word(19'd1000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd2));
      tick();
      check("e_ch3", sensor_data, word(19'd1000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd3));
      tick();
      check("e_drain", {31'b0, data_valid}, 32'd0);
      check("e_ovf", {16'b0, overflow_count}, 32'd0);

      // Two ch1 sweeps behind a stalled ch0 word: second overwrites the first
      data_ready = 1'b0;
      pulse(4'b0001, 32'h0001_0000 + 32'd2000, 10);
      wait_event("f_hold", word(19'd2000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0), lat);
      ticks(2);
      pulse(4'b0010, 32'h0001_0000 + 32'd3000, 10);
      ticks(5);
      pulse(4'b0010, 32'h0001_0000 + 32'd4000, 10);
      ticks(5);
      check("f_ovf", {16'b0, overflow_count}, 32'd1);
      check("f_hold_stable", sensor_data, word(19'd2000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0));
      data_ready = 1'b1;
      tick();
      check("f_second", sensor_data, word(19'd4000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd1));
      check("f_second_valid", {31'b0, data_valid}, 32'd1);
      tick();
      check("f_only_one", {31'b0, data_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
